// File: rtl/execute_stage_mdu.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register
// and an iterative multiply/divide unit that stalls the pipe through busy_e.
module execute_stage_mdu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rd1_e,
  input  logic [XLEN-1:0]   rd2_e,
  input  logic [XLEN-1:0]   pc_e,
  input  logic [XLEN-1:0]   pc_plus4_e,
  input  logic [XLEN-1:0]   imm_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [XLEN-1:0]   result_w,
  input  logic [1:0]        forward_a_e,
  input  logic [1:0]        forward_b_e,
  input  logic              alu_src_e,
  input  logic [3:0]        alu_control_e,
  input  logic              md_en_e,
  input  logic [2:0]        md_op_e,
  input  logic              reg_write_e,
  input  logic              mem_write_e,
  input  logic              jump_e,
  input  logic              branch_e,
  input  logic [1:0]        result_src_e,
  input  logic              flush_e,
  output logic              busy_e,
  output logic [XLEN-1:0]   pc_target_e,
  output logic              pc_src_e,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [XLEN-1:0]   write_data_m,
  output logic [XLEN-1:0]   pc_plus4_m,
  output logic [REG_AW-1:0] rd_m,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic [1:0]        result_src_m
);

  localparam int unsigned SHW  = $clog2(XLEN);
  localparam int unsigned NMAX = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
  localparam int unsigned CW   = $clog2(NMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] DIV_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b_pre;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  always_comb begin
    w_src_a = rd1_e;
    case (forward_a_e)
      2'b01:   w_src_a = result_w;
      2'b10:   w_src_a = alu_result_m;
      default: w_src_a = rd1_e;
    endcase
  end

  always_comb begin
    w_src_b_pre = rd2_e;
    case (forward_b_e)
      2'b01:   w_src_b_pre = result_w;
      2'b10:   w_src_b_pre = alu_result_m;
      default: w_src_b_pre = rd2_e;
    endcase
  end

  assign w_src_b = alu_src_e ? imm_e : w_src_b_pre;

  always_comb begin
    w_alu_result = '0;
    case (alu_control_e)
      4'd0: w_alu_result = w_src_a + w_src_b;
      4'd1: w_alu_result = w_src_a - w_src_b;
      4'd2: w_alu_result = w_src_a & w_src_b;
      4'd3: w_alu_result = w_src_a | w_src_b;
      4'd4: w_alu_result = w_src_a ^ w_src_b;
      4'd5: w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      4'd6: w_alu_result = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
      4'd7: w_alu_result = w_src_a << w_src_b[SHW-1:0];
      4'd8: w_alu_result = w_src_a >> w_src_b[SHW-1:0];
      4'd9: w_alu_result = XLEN'($signed(w_src_a) >>> w_src_b[SHW-1:0]);
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero      = (w_alu_result == '0);
  assign pc_target_e = pc_e + imm_e;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_special;

  logic              w_start;
  logic              w_is_div;
  logic              w_is_rem;
  logic              w_signed_div;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic              w_n_one;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [2*XLEN-1:0] w_ma;
  logic [2*XLEN-1:0] w_mb;
  logic [2*XLEN-1:0] w_mprod;

  assign w_is_div     = md_op_e[2];
  assign w_is_rem     = md_op_e[1];
  assign w_signed_div = ~md_op_e[0];
  assign w_div_zero   = (w_src_b_pre == '0);
  assign w_ovf        = w_signed_div && (w_src_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (w_src_b_pre == '1);
  assign w_special    = w_is_div && (w_div_zero || w_ovf);
  assign w_n_one      = w_special || (!w_is_div && (MUL_LAT == 1));
  assign w_spec_res   = w_div_zero ? (w_is_rem ? w_src_a : '1)
                                   : (w_is_rem ? '0 : w_src_a);

  assign w_a_mag = (w_signed_div && w_src_a[XLEN-1]) ? -w_src_a : w_src_a;
  assign w_b_mag = (w_signed_div && w_src_b_pre[XLEN-1]) ? -w_src_b_pre : w_src_b_pre;

  // Sign-extending to 2*XLEN lets one unsigned multiplier serve all four
  // signedness combinations; the product is correct modulo 2^(2*XLEN).
  assign w_a_sgn = (md_op_e == 3'd1) || (md_op_e == 3'd2);
  assign w_b_sgn = (md_op_e == 3'd1);
  assign w_ma    = {{XLEN{w_a_sgn & w_src_a[XLEN-1]}}, w_src_a};
  assign w_mb    = {{XLEN{w_b_sgn & w_src_b_pre[XLEN-1]}}, w_src_b_pre};
  assign w_mprod = w_ma * w_mb;

  assign w_start = rst && (r_state == S_IDLE) && md_en_e && !flush_e;
  assign busy_e  = w_start || (rst && (r_state == S_RUN) && !flush_e);
  assign pc_src_e = !busy_e && !flush_e && ((w_zero && branch_e) || jump_e);

  // The first restoring step runs in the start cycle on the fresh magnitudes,
  // so XLEN steps finish by the time DONE is reached.
  logic [XLEN-1:0] w_d_rem_in;
  logic [XLEN-1:0] w_d_quo_in;
  logic [XLEN-1:0] w_d_dvs;
  logic [XLEN:0]   w_d_sh;
  logic [XLEN:0]   w_d_diff;
  logic            w_d_ge;
  logic [XLEN-1:0] w_d_rem_nxt;
  logic [XLEN-1:0] w_d_quo_nxt;

  assign w_d_rem_in  = (r_state == S_IDLE) ? '0 : r_rem;
  assign w_d_quo_in  = (r_state == S_IDLE) ? w_a_mag : r_quo;
  assign w_d_dvs     = (r_state == S_IDLE) ? w_b_mag : r_dvs;
  assign w_d_sh      = {w_d_rem_in, w_d_quo_in[XLEN-1]};
  assign w_d_diff    = w_d_sh - {1'b0, w_d_dvs};
  assign w_d_ge      = ~w_d_diff[XLEN];
  assign w_d_rem_nxt = w_d_ge ? w_d_diff[XLEN-1:0] : w_d_sh[XLEN-1:0];
  assign w_d_quo_nxt = {w_d_quo_in[XLEN-2:0], w_d_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_prod    <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
    end else if (flush_e) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md_en_e) begin
            r_op      <= md_op_e;
            r_prod    <= w_special ? {{XLEN{1'b0}}, w_spec_res} : w_mprod;
            r_special <= w_special;
            r_neg_q   <= w_signed_div && (w_src_a[XLEN-1] ^ w_src_b_pre[XLEN-1]);
            r_neg_r   <= w_signed_div && w_src_a[XLEN-1];
            r_dvs     <= w_b_mag;
            r_rem     <= w_d_rem_nxt;
            r_quo     <= w_d_quo_nxt;
            r_cnt     <= w_is_div ? DIV_LOAD : MUL_LOAD;
            r_state   <= w_n_one ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_d_rem_nxt;
          r_quo <= w_d_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [XLEN-1:0] w_md_result;

  always_comb begin
    w_md_result = '0;
    if (r_special) begin
      w_md_result = r_prod[XLEN-1:0];
    end else if (r_op[2]) begin
      if (r_op[1]) w_md_result = r_neg_r ? -r_rem : r_rem;
      else         w_md_result = r_neg_q ? -r_quo : r_quo;
    end else if (r_op[1:0] == 2'd0) begin
      w_md_result = r_prod[XLEN-1:0];
    end else begin
      w_md_result = r_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else if (flush_e || busy_e) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else begin
      alu_result_m <= (r_state == S_DONE) ? w_md_result : w_alu_result;
      write_data_m <= w_src_b_pre;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
    end
  end

endmodule
